// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
//   PWM_W              default field width of a PWM word
//   PERIOD_HI/LO       bit slice of the {period-1} field in a PWM word
//   DUTY_HI/LO         bit slice of the {high-1} field in a PWM word
//   pwm_state_e        capture FSM state encoding
package pwm_pkg;

  localparam int PWM_W     = 8;

  localparam int PERIOD_HI = 2*PWM_W - 1;
  localparam int PERIOD_LO = PWM_W;
  localparam int DUTY_HI   = PWM_W - 1;
  localparam int DUTY_LO   = 0;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pwm_state_e;

  // Plain constants for modules that keep the state in a logic vector.
  localparam logic [0:0] ST_IDLE    = IDLE;
  localparam logic [0:0] ST_MEASURE = MEASURE;

endpackage

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and the capture block.
//   pwm_in       PWM line (may be asynchronous to the capture clock)
//   pwm_word     {period-1, high-1} of the last complete period
//   word_valid   1-cycle pulse when pwm_word updates
//   timeout      1-cycle pulse when no rising edge arrives in 2**WIDTH cycles
//   stuck_level  synchronized line level at the last timeout
// master: drives the line and observes results; slave: the capture block.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_W
) ();

  logic                 pwm_in;
  logic [2*WIDTH-1:0]   pwm_word;
  logic                 word_valid;
  logic                 timeout;
  logic                 stuck_level;

  modport master (
    output pwm_in,
    input  pwm_word,
    input  word_valid,
    input  timeout,
    input  stuck_level
  );

  modport slave (
    input  pwm_in,
    output pwm_word,
    output word_valid,
    output timeout,
    output stuck_level
  );

endinterface

// File: rtl/pwm_sync_edge.sv
// Synchronizer and rising-edge detector for the PWM line.
//   clk      system clock
//   reset    synchronous, active-high reset (clears every flop)
//   d        raw, possibly asynchronous input
//   lvl      synchronized level (output of the last sync flop)
//   rise     high for one cycle when lvl goes 0 -> 1
// SYNC_STAGES must be at least 2.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      lvl_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      lvl_d  <= lvl;
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of the incoming PWM line and
// publishes them as {period-1, high-1}, the same layout the generator takes.
//   clk          system clock
//   reset        synchronous, active-high reset
//   bus          pwm_capture_if.slave: pwm_in in; pwm_word, word_valid,
//                timeout, stuck_level out
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no reference edge yet; waiting for a rise to start measuring
// MEASURE | counting the period that began at the last rise
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  pwm_capture_if.slave   bus
);

  localparam logic [WIDTH:0] CNT_ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] CNT_MAX = {1'b1, {WIDTH{1'b0}}};

  logic             lvl;
  logic             rise;
  logic [0:0]       state;
  logic [WIDTH:0]   period_cnt;
  logic [WIDTH:0]   high_cnt;
  logic [WIDTH-1:0] period_field;
  logic [WIDTH-1:0] high_field;

  pwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.pwm_in),
    .lvl   (lvl),
    .rise  (rise)
  );

  // A full 2**WIDTH period counts to CNT_MAX; minus one it fits WIDTH bits
  // as all-ones, so truncation is exact for every legal period.
  assign period_field = WIDTH'(period_cnt - CNT_ONE);
  assign high_field   = WIDTH'(high_cnt - CNT_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      period_cnt      <= '0;
      high_cnt        <= '0;
      bus.pwm_word    <= '0;
      bus.word_valid  <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.stuck_level <= 1'b0;
    end else begin
      bus.word_valid <= 1'b0;
      bus.timeout    <= 1'b0;

      case (state)
        ST_IDLE: begin
          // The partial period before the first edge is never published.
          if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
            state      <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (rise) begin
            // A rise exactly at CNT_MAX is still a legal full-length period.
            bus.pwm_word   <= {period_field, high_field};
            bus.word_valid <= 1'b1;
            period_cnt     <= CNT_ONE;
            high_cnt       <= CNT_ONE;
          end else if (period_cnt == CNT_MAX) begin
            bus.timeout     <= 1'b1;
            bus.stuck_level <= lvl;
            state           <= ST_IDLE;
          end else begin
            // Every high cycle counts, glitches included.
            period_cnt <= period_cnt + CNT_ONE;
            high_cnt   <= high_cnt + {{WIDTH{1'b0}}, lvl};
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. The reference model keeps the whole
// driven waveform, finds rising edges of the synchronizer-delayed line and
// derives each published word by counting cycles between edges.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int W    = PWM_W;
  localparam int SYNC = 2;
  localparam int PMAX = 1 << W;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pwm_capture_if #(.WIDTH(W)) bus ();

  pwm_capture #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic           hist[$];
  bit             armed;
  int             last_rise;
  logic [2*W-1:0] e_word;
  logic           e_valid;
  logic           e_to;
  logic           e_stuck;
  int             obs_valid;
  int             obs_to;

  logic           stim[$];

  task automatic model_reset();
    hist.delete();
    armed     = 1'b0;
    last_rise = 0;
    e_word    = '0;
    e_valid   = 1'b0;
    e_to      = 1'b0;
    e_stuck   = 1'b0;
  endtask

  task automatic add_run(input logic b, input int n);
    repeat (n) stim.push_back(b);
  endtask

  // Drive one input bit for one clock and advance the model to that edge.
  // The line as seen by the measurement at edge e is the input of edge e-SYNC.
  task automatic step(input logic b);
    int   e;
    int   p;
    int   h;
    logic lv;
    logic lv_p;
    @(negedge clk);
    bus.pwm_in = b;
    @(posedge clk);
    #1;
    hist.push_back(b);
    e    = hist.size() - 1;
    lv   = (e >= SYNC)     ? hist[e-SYNC]   : 1'b0;
    lv_p = (e >= SYNC + 1) ? hist[e-SYNC-1] : 1'b0;
    e_valid = 1'b0;
    e_to    = 1'b0;
    if (lv && !lv_p) begin
      if (armed) begin
        p = e - last_rise;
        h = 0;
        for (int x = last_rise; x < e; x++)
          if (x >= SYNC) h += int'(hist[x-SYNC]);
        e_word  = {W'(p - 1), W'(h - 1)};
        e_valid = 1'b1;
      end
      armed     = 1'b1;
      last_rise = e;
    end else if (armed && (e - last_rise) == PMAX) begin
      e_to    = 1'b1;
      e_stuck = lv;
      armed   = 1'b0;
    end
    obs_valid += int'(bus.word_valid);
    obs_to    += int'(bus.timeout);
  endtask

  task automatic test_reset();
    bus.pwm_in = 1'b0;
    reset      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.pwm_in = 1'($urandom);
      @(posedge clk);
      #1;
      vectors++;
      if ({bus.word_valid, bus.timeout, bus.stuck_level, bus.pwm_word} !== '0) begin
        miscompares++;
        $display("FAIL reset: got v=%b t=%b s=%b w=%h, want all 0",
                 bus.word_valid, bus.timeout, bus.stuck_level, bus.pwm_word);
      end
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_hhll();
    obs_valid = 0;
    obs_to    = 0;
    stim.delete();
    for (int k = 0; k < 10; k++) begin add_run(1'b1, 2); add_run(1'b0, 2); end
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL hhll @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
    vectors++;
    if (obs_valid !== 9 || bus.pwm_word !== 16'h0301) begin
      miscompares++;
      $display("FAIL hhll_summary: got %0d words last %h, want 9 words last 0301",
               obs_valid, bus.pwm_word);
    end
  endtask

  task automatic test_hl();
    obs_valid = 0;
    obs_to    = 0;
    stim.delete();
    for (int k = 0; k < 20; k++) begin add_run(1'b1, 1); add_run(1'b0, 1); end
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL hl @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
    vectors++;
    if (obs_to !== 0 || obs_valid !== 19 || bus.pwm_word !== 16'h0100) begin
      miscompares++;
      $display("FAIL hl_summary: got %0d timeouts %0d words last %h, want 0, 19, 0100",
               obs_to, obs_valid, bus.pwm_word);
    end
  endtask

  task automatic test_wide();
    obs_valid = 0;
    obs_to    = 0;
    stim.delete();
    for (int k = 0; k < 3; k++) begin add_run(1'b1, 128); add_run(1'b0, 128); end
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL wide @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
    vectors++;
    if (bus.pwm_word[PERIOD_HI:PERIOD_LO] !== 8'hFF || bus.pwm_word[DUTY_HI:DUTY_LO] !== 8'h7F
        || obs_to !== 0) begin
      miscompares++;
      $display("FAIL wide_summary: got word %h timeouts %0d, want FF7F and 0",
               bus.pwm_word, obs_to);
    end
  endtask

  task automatic test_stretch();
    obs_valid = 0;
    obs_to    = 0;
    stim.delete();
    add_run(1'b1, 128); add_run(1'b0, 129);
    add_run(1'b1, 128); add_run(1'b0, 128);
    add_run(1'b1, 128); add_run(1'b0, 128);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL stretch @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
    vectors++;
    if (obs_to !== 1 || obs_valid !== 2 || bus.stuck_level !== 1'b0 ||
        bus.pwm_word !== 16'hFF7F) begin
      miscompares++;
      $display("FAIL stretch_summary: got to=%0d words=%0d s=%b w=%h, want 1, 2, 0, FF7F",
               obs_to, obs_valid, bus.stuck_level, bus.pwm_word);
    end
  endtask

  task automatic test_stuck();
    obs_valid = 0;
    obs_to    = 0;
    stim.delete();
    for (int k = 0; k < 4; k++) begin add_run(1'b1, 2); add_run(1'b0, 2); end
    add_run(1'b1, 300);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL stuck @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
    vectors++;
    if (obs_to !== 1 || bus.stuck_level !== 1'b1 || bus.pwm_word !== 16'h0301) begin
      miscompares++;
      $display("FAIL stuck_hold: got to=%0d s=%b w=%h, want 1, 1, 0301",
               obs_to, bus.stuck_level, bus.pwm_word);
    end
    obs_valid = 0;
    stim.delete();
    add_run(1'b0, 2);
    for (int k = 0; k < 4; k++) begin add_run(1'b1, 2); add_run(1'b0, 2); end
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL stuck_resume @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
    vectors++;
    if (obs_valid !== 3 || bus.pwm_word !== 16'h0301) begin
      miscompares++;
      $display("FAIL stuck_resume_summary: got %0d words last %h, want 3 and 0301",
               obs_valid, bus.pwm_word);
    end
  endtask

  task automatic test_reset_mid();
    stim.delete();
    for (int k = 0; k < 3; k++) begin add_run(1'b1, 3); add_run(1'b0, 5); end
    add_run(1'b1, 3); add_run(1'b0, 2);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL rstmid_pre @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
    @(negedge clk);
    reset      = 1'b1;
    bus.pwm_in = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.word_valid, bus.timeout, bus.stuck_level, bus.pwm_word} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_clear: got v=%b t=%b s=%b w=%h, want all 0",
               bus.word_valid, bus.timeout, bus.stuck_level, bus.pwm_word);
    end
    reset = 1'b0;
    model_reset();
    obs_valid = 0;
    obs_to    = 0;
    stim.delete();
    add_run(1'b0, 3);
    for (int k = 0; k < 3; k++) begin add_run(1'b1, 3); add_run(1'b0, 5); end
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL rstmid_post @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
    vectors++;
    if (obs_valid !== 2 || bus.pwm_word !== 16'h0702) begin
      miscompares++;
      $display("FAIL rstmid_summary: got %0d words last %h, want 2 and 0702",
               obs_valid, bus.pwm_word);
    end
  endtask

  task automatic test_random();
    int p;
    int h;
    stim.delete();
    for (int k = 0; k < 15; k++) begin
      if ($urandom_range(0, 5) == 0) p = $urandom_range(PMAX + 1, PMAX + 40);
      else                           p = $urandom_range(2, PMAX);
      h = $urandom_range(1, (p > PMAX ? PMAX : p) - 1);
      add_run(1'b1, h);
      add_run(1'b0, p - h);
    end
    add_run(1'b1, 4);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      vectors++;
      if (bus.word_valid !== e_valid || bus.timeout !== e_to ||
          bus.pwm_word !== e_word || bus.stuck_level !== e_stuck) begin
        miscompares++;
        $display("FAIL random @%0d: got v=%b t=%b w=%h s=%b, want v=%b t=%b w=%h s=%b",
                 i, bus.word_valid, bus.timeout, bus.pwm_word, bus.stuck_level,
                 e_valid, e_to, e_word, e_stuck);
      end
    end
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    obs_valid  = 0;
    obs_to     = 0;
    model_reset();
    test_reset();
    test_hhll();
    test_hl();
    test_wide();
    test_stretch();
    test_stuck();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
